// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-format definitions: op types, func3 subtypes, field
// positions and immediate widths. The decoder uses the same layout.
package instr_encoder_loader_pkg;

    typedef enum logic [2:0] {
        OP_A = 3'd0,
        OP_B = 3'd1,
        OP_C = 3'd2,
        OP_D = 3'd3,
        OP_E = 3'd4,
        OP_F = 3'd5,
        OP_G = 3'd6,
        OP_H = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        D_CLIR = 3'd0,
        D_LUI  = 3'd1,
        D_JAL  = 3'd2
    } func3_d_e;

    typedef enum logic [2:0] {
        F_LB  = 3'd0,
        F_LH  = 3'd1,
        F_LW  = 3'd2,
        F_LBU = 3'd4,
        F_LHU = 3'd5
    } func3_f_e;

    // Loader session states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Field positions. Formats C and G place rs2 in the rd slot.
    localparam int unsigned OP_LSB    = 0;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned F3_LSB    = 3;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned RD_LSB    = 6;
    localparam int unsigned RS1_LSB   = 11;
    localparam int unsigned RS2_LSB   = 16;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned F11_LSB   = 21;
    localparam int unsigned F11_W     = 11;
    localparam int unsigned IMM16_LSB = 16;
    localparam int unsigned IMM_D_LSB = 11;

    // Signed immediate widths
    localparam int unsigned IMM_W_BCF = 16;
    localparam int unsigned IMM_W_D   = 21;
    localparam int unsigned IMM_W_G   = 18;

    // True when value is representable as a signed number of the given width.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned width);
        logic signed [31:0] upper;
        upper = $signed(value) >>> (width - 1);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_sync_fifo.sv
// Small synchronous FIFO holding encoded instruction words. Read data is
// the current head, available combinationally while not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction field bundles into 32-bit words, buffers them and
// writes them sequentially to instruction memory while the core is stalled.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start; no session active
// LOAD     | accepting bundles until one marked last is accepted
// DRAIN    | no new bundles; waiting for the buffer to empty
// DONE     | one-cycle done pulse, then back to IDLE
module instr_encoder_loader #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_func3,
    input  logic [10:0]       in_func11,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              core_stall,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import instr_encoder_loader_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    op_e               op;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fifo_head;

    assign op = op_e'(in_op);

    // Field packing and range check for the bundle currently offered
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        enc_word[OP_LSB +: OP_W] = in_op;
        enc_word[F3_LSB +: F3_W] = in_func3;
        case (op)
            OP_A: begin
                enc_word[RD_LSB  +: REG_W] = in_rd;
                enc_word[RS1_LSB +: REG_W] = in_rs1;
                enc_word[RS2_LSB +: REG_W] = in_rs2;
                enc_word[F11_LSB +: F11_W] = in_func11;
            end
            OP_B: begin
                enc_word[RD_LSB    +: REG_W]     = in_rd;
                enc_word[RS1_LSB   +: REG_W]     = in_rs1;
                enc_word[IMM16_LSB +: IMM_W_BCF] = in_imm[IMM_W_BCF-1:0];
                // Shift amounts are unsigned 0..31 rather than signed 16-bit
                if (in_func3[2]) enc_ok = (in_imm[31:5] == '0);
                else             enc_ok = fits_signed(in_imm, IMM_W_BCF);
            end
            OP_F: begin
                enc_word[RD_LSB    +: REG_W]     = in_rd;
                enc_word[RS1_LSB   +: REG_W]     = in_rs1;
                enc_word[IMM16_LSB +: IMM_W_BCF] = in_imm[IMM_W_BCF-1:0];
                enc_ok = fits_signed(in_imm, IMM_W_BCF);
            end
            OP_C: begin
                enc_word[RD_LSB    +: REG_W]     = in_rs2;
                enc_word[RS1_LSB   +: REG_W]     = in_rs1;
                enc_word[IMM16_LSB +: IMM_W_BCF] = in_imm[IMM_W_BCF-1:0];
                enc_ok = fits_signed(in_imm, IMM_W_BCF);
            end
            OP_D: begin
                enc_word[RD_LSB    +: REG_W]   = in_rd;
                enc_word[IMM_D_LSB +: IMM_W_D] = in_imm[IMM_W_D-1:0];
                enc_ok = fits_signed(in_imm, IMM_W_D);
            end
            OP_G: begin
                // Byte offset is word aligned; the two zero LSBs are not stored
                enc_word[RD_LSB    +: REG_W]     = in_rs2;
                enc_word[RS1_LSB   +: REG_W]     = in_rs1;
                enc_word[IMM16_LSB +: IMM_W_BCF] = in_imm[IMM_W_G-1:2];
                enc_ok = fits_signed(in_imm, IMM_W_G) && (in_imm[1:0] == 2'b00);
            end
            default: enc_ok = 1'b0;
        endcase
    end

    // in_ready uses the registered full flag only, so a pop in the same
    // cycle never lets a push through.
    assign in_ready   = (state_q == ST_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign fifo_push  = accept && enc_ok;
    assign imem_we    = !fifo_empty;
    assign fifo_pop   = imem_we && imem_ready;
    assign imem_addr  = addr_q;
    assign imem_wdata = fifo_empty ? 32'h0 : fifo_head;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign core_stall = busy;
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (enc_word),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic: session sequencing, write address and sticky error
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        if (fifo_pop) addr_d = addr_q + ADDR_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = base_addr;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept && !enc_ok) err_d = 1'b1;
                // A dropped last bundle still closes the session
                if (accept && in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, address and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with hand-computed expected words.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_op;
    logic [2:0]        in_func3;
    logic [10:0]       in_func11;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;
    logic              core_stall;
    logic              busy;
    logic              done;
    logic              err;

    instr_encoder_loader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_op      (in_op),
        .in_func3   (in_func3),
        .in_func11  (in_func11),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .core_stall (core_stall),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    int                done_cnt  = 0;
    logic              stall_bad = 1'b0;

    // Memory write log, done pulse counter and stall/busy tracking
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
        if (done) done_cnt++;
        if (core_stall !== busy) stall_bad = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bundle(input logic [2:0] op, input logic [2:0] f3, input logic [10:0] f11,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic last);
        in_valid  = 1'b1;
        in_op     = op;
        in_func3  = f3;
        in_func11 = f11;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_last   = last;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [10:0] f11,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        logic acc;
        acc = 1'b0;
        set_bundle(op, f3, f11, rd, rs1, rs2, imm, last);
        for (int i = 0; i < 40; i++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        chk("send_accepted", 32'(acc), 32'h1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!busy) break;
        end
        chk({tag, "_done_pulse"}, 32'(done), 32'h1);
        tick();
        chk({tag, "_done_low"}, 32'(done), 32'h0);
    endtask

    // Type A bundle k of the backpressure run
    task automatic set_bundle_a(input int k);
        set_bundle(3'(OP_A), 3'(k), 11'(k * 3), 5'(k), 5'(k + 3), 5'(k + 1), 32'h0, (k == 5));
    endtask

    function automatic logic [31:0] enc_a(input int k);
        return {11'(k * 3), 5'(k + 1), 5'(k + 3), 5'(k), 3'(k), 3'd0};
    endfunction

    int   b;
    int   d0;
    int   k;
    logic acc;
    logic stable_bad;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; imem_ready = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_op = '0; in_func3 = '0; in_func11 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        #2;
        chk("rst_ctrl", {26'h0, in_ready, imem_we, core_stall, busy, done, err}, 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        #10;
        rst_n = 1'b1;
        tick();
        tick();

        // Bundles offered in IDLE are ignored
        set_bundle(3'(OP_A), 3'd0, 11'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1);
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("idle_no_we", 32'(imem_we), 32'h0);
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Session 1: A then B (last)
        b = wa.size(); d0 = done_cnt;
        start_session(12'h010);
        send(3'(OP_A), 3'd0, 11'd0, 5'd2, 5'd1, 5'd3, 32'h0, 1'b0);
        send(3'(OP_B), 3'd1, 11'd0, 5'd4, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        wait_idle("s1");
        chk("s1_nwr", 32'(wa.size() - b), 32'd2);
        chk("s1_addr0", 32'(wa[b]), 32'h010);
        chk("s1_data0", wd[b], 32'h0003_0880);
        chk("s1_addr1", 32'(wa[b+1]), 32'h011);
        chk("s1_data1", wd[b+1], 32'hFFFF_0909);
        chk("s1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("s1_err", 32'(err), 32'h0);

        // Session 2: G ok, G misaligned (dropped), D CLIR last
        b = wa.size(); d0 = done_cnt;
        start_session(12'h100);
        send(3'(OP_G), 3'd1, 11'd0, 5'd0, 5'd5, 5'd6, 32'd8, 1'b0);
        send(3'(OP_G), 3'd1, 11'd0, 5'd0, 5'd5, 5'd6, 32'd6, 1'b0);
        chk("s2_err_set", 32'(err), 32'h1);
        send(3'(OP_D), 3'(D_CLIR), 11'd0, 5'd7, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b1);
        wait_idle("s2");
        chk("s2_nwr", 32'(wa.size() - b), 32'd2);
        chk("s2_data0", wd[b], 32'h0002_298E);
        chk("s2_addr1", 32'(wa[b+1]), 32'h101);
        chk("s2_data1", wd[b+1], 32'hFFFF_E1C3);
        chk("s2_err_sticky", 32'(err), 32'h1);

        // Session 3: memory backpressure with six bundles offered
        b = wa.size();
        imem_ready = 1'b0;
        start_session(12'h200);
        k = 0;
        stable_bad = 1'b0;
        set_bundle_a(k);
        for (int c = 0; c < 5; c++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                k++;
                set_bundle_a(k);
            end
            if (imem_we && (imem_addr !== 12'h200 || imem_wdata !== enc_a(0))) stable_bad = 1'b1;
        end
        chk("bp_accepted", 32'(k), 32'd4);
        chk("bp_in_ready_low", 32'(in_ready), 32'h0);
        chk("bp_stable", 32'(stable_bad), 32'h0);
        chk("bp_no_writes", 32'(wa.size() - b), 32'd0);
        imem_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (k == 6) break;
            acc = in_ready;
            tick();
            if (acc) begin
                k++;
                if (k < 6) set_bundle_a(k);
                else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
        end
        chk("bp_all_accepted", 32'(k), 32'd6);
        wait_idle("bp");
        chk("bp_nwr", 32'(wa.size() - b), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("bp_addr", 32'(wa[b+i]), 32'h200 + 32'(i));
            chk("bp_data", wd[b+i], enc_a(i));
        end

        // Session 4: C and B shift across the address wrap
        b = wa.size();
        start_session(12'hFFF);
        send(3'(OP_C), 3'd2, 11'd0, 5'd0, 5'd3, 5'd9, 32'h0000_7FFF, 1'b0);
        send(3'(OP_B), 3'd4, 11'd0, 5'd1, 5'd2, 5'd0, 32'd31, 1'b1);
        wait_idle("s4");
        chk("s4_nwr", 32'(wa.size() - b), 32'd2);
        chk("s4_addr0", 32'(wa[b]), 32'hFFF);
        chk("s4_data0", wd[b], 32'h7FFF_1A52);
        chk("s4_addr1", 32'(wa[b+1]), 32'h000);
        chk("s4_data1", wd[b+1], 32'h001F_1061);
        chk("s4_err", 32'(err), 32'h0);

        // Session 5: shift out of range, then op E with last
        b = wa.size(); d0 = done_cnt;
        start_session(12'h300);
        send(3'(OP_B), 3'd4, 11'd0, 5'd1, 5'd2, 5'd0, 32'd32, 1'b0);
        chk("s5_shift_err", 32'(err), 32'h1);
        send(3'(OP_E), 3'd0, 11'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1);
        wait_idle("s5");
        chk("s5_nwr", 32'(wa.size() - b), 32'd0);
        chk("s5_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("s5_err", 32'(err), 32'h1);

        // Session 6: start clears err; reset with two words queued
        b = wa.size();
        imem_ready = 1'b0;
        start_session(12'h400);
        chk("s6_err_cleared", 32'(err), 32'h0);
        send(3'(OP_A), 3'd0, 11'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        send(3'(OP_A), 3'd0, 11'd0, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0);
        chk("s6_we_queued", 32'(imem_we), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {26'h0, in_ready, imem_we, core_stall, busy, done, err}, 32'h0);
        chk("mid_rst_addr", 32'(imem_addr), 32'h0);
        chk("mid_rst_wdata", imem_wdata, 32'h0);
        imem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_no_writes", 32'(wa.size() - b), 32'd0);
        chk("post_rst_idle", {30'h0, busy, imem_we}, 32'h0);

        chk("stall_tracks_busy", 32'(stall_bad), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
